// File: rtl/idelay_tap_calibrator.sv
// idelay_tap_calibrator: sweeps one VAR_LOAD delay tap, scores each tap against the checker stream, loads the centre of the widest passing window.
// Latency: 3 + (MAX_TAP+1)*(1+SETTLE_CYCLES+SAMPLE_CYCLES) - 1 + SETTLE_CYCLES + 1 cycles from START to DONE with continuous SAMPLE_VALID.
// Backpressure: none upstream; SAMPLE waits without timeout for SAMPLE_VALID. Optional CNTVALUEOUT readback check under `define IDLY_CAL_READBACK_EN.
module idelay_tap_calibrator #(
  parameter int MAX_TAP       = 511,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16,
  parameter int MIN_EYE       = 4,
  parameter int FALLBACK_TAP  = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       SAMPLE_VALID,
  input  logic       SAMPLE_OK,
  input  logic [8:0] CNTVALUEOUT,
  output logic       CE,
  output logic       INC,
  output logic       LOAD,
  output logic [8:0] CNTVALUEIN,
  output logic       EN_VTC,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAIL,
  output logic [8:0] CENTER_TAP,
  output logic [9:0] EYE_WIDTH
);

  localparam int SETW = $clog2(SETTLE_CYCLES + 1);
  localparam int SAMW = $clog2(SAMPLE_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE,
    VTC_OFF,
    LOAD0,
    SETTLE,
    SAMPLE,
    STEP,
    APPLY,
    APPLY_SETTLE,
    FINISH
  } state_t;

  state_t          state;
  logic [8:0]      tap;
  logic [SETW-1:0] settle_cnt;
  logic [SAMW-1:0] sample_cnt;
  logic            tap_ok;
  logic [9:0]      run_len;
  logic [8:0]      run_start;
  logic [9:0]      best_len;
  logic [8:0]      best_start;
  logic            rb_err;

  logic            sample_last;
  logic            tap_pass;
  logic [9:0]      run_len_nx;
  logic [8:0]      run_start_nx;
  logic [9:0]      best_len_nx;
  logic [8:0]      best_start_nx;
  logic            apply_ok;
  logic [8:0]      apply_tap;
  logic            rb_mismatch;

  // Window tracker next-state and the tap that APPLY would load, so the final
  // sample of the last tap can go straight into the APPLY load pulse.
  always_comb begin
    sample_last   = SAMPLE_VALID && (sample_cnt == SAMW'(SAMPLE_CYCLES - 1));
    tap_pass      = tap_ok && SAMPLE_OK;
    run_len_nx    = run_len;
    run_start_nx  = run_start;
    best_len_nx   = best_len;
    best_start_nx = best_start;
    if (state == SAMPLE && sample_last) begin
      if (tap_pass) begin
        if (run_len == 10'd0) run_start_nx = tap;
        run_len_nx = run_len + 10'd1;
        // Strict compare: on a tie the earlier window is kept.
        if (run_len_nx > best_len) begin
          best_len_nx   = run_len_nx;
          best_start_nx = run_start_nx;
        end
      end else begin
        run_len_nx = 10'd0;
      end
    end
    apply_ok  = (best_len_nx >= 10'(MIN_EYE));
    apply_tap = apply_ok ? (best_start_nx + 9'(best_len_nx >> 1)) : 9'(FALLBACK_TAP);
  end

`ifdef IDLY_CAL_READBACK_EN
  logic [8:0] expect_tap;

  // Tap the delay element should report on the last settle cycle.
  always_comb begin
    expect_tap = (state == APPLY_SETTLE) ? CENTER_TAP : tap;
  end
  assign rb_mismatch = (CNTVALUEOUT != expect_tap);
`else
  logic unused_cntvalueout;
  assign unused_cntvalueout = ^CNTVALUEOUT;
  assign rb_mismatch        = 1'b0;
`endif

  // Calibration sequencer with registered delay-element controls and status.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      CE         <= 1'b0;
      INC        <= 1'b0;
      LOAD       <= 1'b0;
      CNTVALUEIN <= 9'd0;
      EN_VTC     <= 1'b1;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      FAIL       <= 1'b0;
      CENTER_TAP <= 9'd0;
      EYE_WIDTH  <= 10'd0;
      tap        <= 9'd0;
      settle_cnt <= '0;
      sample_cnt <= '0;
      tap_ok     <= 1'b0;
      run_len    <= 10'd0;
      run_start  <= 9'd0;
      best_len   <= 10'd0;
      best_start <= 9'd0;
      rb_err     <= 1'b0;
    end else begin
      // Control strobes are single-cycle pulses unless a state asserts them.
      CE   <= 1'b0;
      INC  <= 1'b0;
      LOAD <= 1'b0;
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          EN_VTC <= 1'b1;
          BUSY   <= 1'b0;
          if (START) begin
            state      <= VTC_OFF;
            EN_VTC     <= 1'b0;
            BUSY       <= 1'b1;
            FAIL       <= 1'b0;
            EYE_WIDTH  <= 10'd0;
            run_len    <= 10'd0;
            run_start  <= 9'd0;
            best_len   <= 10'd0;
            best_start <= 9'd0;
            rb_err     <= 1'b0;
          end
        end
        VTC_OFF: begin
          state      <= LOAD0;
          CE         <= 1'b1;
          LOAD       <= 1'b1;
          CNTVALUEIN <= 9'd0;
          tap        <= 9'd0;
        end
        LOAD0, STEP: begin
          state      <= SETTLE;
          settle_cnt <= SETW'(SETTLE_CYCLES - 1);
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            if (rb_mismatch) begin
              // Delay element disagrees with our tap count: abandon the sweep.
              state      <= APPLY;
              CE         <= 1'b1;
              LOAD       <= 1'b1;
              CNTVALUEIN <= 9'(FALLBACK_TAP);
              CENTER_TAP <= 9'(FALLBACK_TAP);
              EYE_WIDTH  <= 10'd0;
              FAIL       <= 1'b1;
              rb_err     <= 1'b1;
            end else begin
              state      <= SAMPLE;
              sample_cnt <= '0;
              tap_ok     <= 1'b1;
            end
          end else begin
            settle_cnt <= settle_cnt - SETW'(1);
          end
        end
        SAMPLE: begin
          if (SAMPLE_VALID) begin
            sample_cnt <= sample_cnt + SAMW'(1);
            if (!SAMPLE_OK) tap_ok <= 1'b0;
          end
          if (sample_last) begin
            run_len    <= run_len_nx;
            run_start  <= run_start_nx;
            best_len   <= best_len_nx;
            best_start <= best_start_nx;
            if (tap == 9'(MAX_TAP)) begin
              state      <= APPLY;
              CE         <= 1'b1;
              LOAD       <= 1'b1;
              CNTVALUEIN <= apply_tap;
              CENTER_TAP <= apply_tap;
              EYE_WIDTH  <= best_len_nx;
              if (!apply_ok) FAIL <= 1'b1;
            end else begin
              state <= STEP;
              CE    <= 1'b1;
              INC   <= 1'b1;
              tap   <= tap + 9'd1;
            end
          end
        end
        APPLY: begin
          state      <= APPLY_SETTLE;
          settle_cnt <= SETW'(SETTLE_CYCLES - 1);
        end
        APPLY_SETTLE: begin
          if (settle_cnt == '0) begin
            if (rb_mismatch && !rb_err) begin
              // Final tap did not land; retry once with the fallback tap.
              state      <= APPLY;
              CE         <= 1'b1;
              LOAD       <= 1'b1;
              CNTVALUEIN <= 9'(FALLBACK_TAP);
              CENTER_TAP <= 9'(FALLBACK_TAP);
              EYE_WIDTH  <= 10'd0;
              FAIL       <= 1'b1;
              rb_err     <= 1'b1;
            end else begin
              if (rb_mismatch) begin
                FAIL      <= 1'b1;
                EYE_WIDTH <= 10'd0;
              end
              state  <= FINISH;
              EN_VTC <= 1'b1;
              DONE   <= 1'b1;
              BUSY   <= 1'b0;
            end
          end else begin
            settle_cnt <= settle_cnt - SETW'(1);
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/idelay_tap_calibrator.md
# idelay_tap_calibrator

Sweeps the 9-bit tap of one variable input delay element (VAR_LOAD, COUNT format) across its range, scores each tap against a pass/fail stream from the downstream pattern checker, and loads the centre of the widest passing window. It sits beside the delay element in the receive lane and owns its CE/INC/LOAD/CNTVALUEIN/EN_VTC controls for the duration of calibration. VT compensation is held off while calibration runs.

## Interface
Parameters:
- MAX_TAP, 511: last tap swept; range 1..511.
- SETTLE_CYCLES, 8: idle cycles after every tap change before sampling; ≥1.
- SAMPLE_CYCLES, 16: valid samples scored per tap; ≥1.
- MIN_EYE, 4: minimum passing window width for success.
- FALLBACK_TAP, 0: tap loaded on failure.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset; synchronous, active-high.
- START  in  1  begin calibration; sampled in IDLE only.
- SAMPLE_VALID  in  1  checker result valid this cycle.
- SAMPLE_OK  in  1  checker result: data matched; qualified by SAMPLE_VALID.
- CNTVALUEOUT  in  9  current tap reported by the delay element.
- CE  out  1  delay element enable.
- INC  out  1  increment (with CE, LOAD=0).
- LOAD  out  1  load CNTVALUEIN (with CE).
- CNTVALUEIN  out  9  tap to load.
- EN_VTC  out  1  VT compensation enable.
- BUSY  out  1  calibration in progress.
- DONE  out  1  one-cycle pulse at completion.
- FAIL  out  1  sticky until next START: no eye / readback error.
- CENTER_TAP  out  9  tap applied at completion.
- EYE_WIDTH  out  10  widest passing window width, taps.

## Operation
- States: IDLE, VTC_OFF, LOAD0, SETTLE, SAMPLE, STEP, APPLY, APPLY_SETTLE, FINISH.
- IDLE: EN_VTC=1, CE=0. START=1 → VTC_OFF; clears FAIL, EYE_WIDTH, window trackers; BUSY=1.
- VTC_OFF: EN_VTC=0, one cycle → LOAD0.
- LOAD0: CE=1, LOAD=1, CNTVALUEIN=0 for one cycle; tap counter=0 → SETTLE.
- SETTLE: CE=0 for SETTLE_CYCLES → SAMPLE.
- SAMPLE: counts SAMPLE_VALID cycles to SAMPLE_CYCLES; tap passes iff every counted SAMPLE_OK=1. Invalid cycles not counted; no timeout. Then → STEP, or → APPLY if tap==MAX_TAP.
- STEP: CE=1, INC=1, LOAD=0 one cycle; tap counter+1 → SETTLE. Controller never issues decrement (CE=1, INC=0, LOAD=0).
- Window tracking: pass → if run_len==0 run_start=tap; run_len+1; if new run_len > best_len (strict) copy to best. Fail → run_len=0. Ties keep earliest window. Run at MAX_TAP closes by the same compare.
- APPLY: if best_len ≥ MIN_EYE: CNTVALUEIN = best_start + (best_len>>1); else CNTVALUEIN=FALLBACK_TAP, FAIL=1. CE=1, LOAD=1 one cycle; CENTER_TAP, EYE_WIDTH=best_len latched → APPLY_SETTLE.
- APPLY_SETTLE: SETTLE_CYCLES → FINISH.
- FINISH: EN_VTC=1, DONE=1, BUSY=0 for one cycle → IDLE.
- Arithmetic: tap counter 9 bits, never wraps (stops at MAX_TAP); run/best lengths 10 bits (max 512).

## Timing
- Reset values: CE=0, INC=0, LOAD=0, CNTVALUEIN=0, EN_VTC=1, BUSY=0, DONE=0, FAIL=0, CENTER_TAP=0, EYE_WIDTH=0; state IDLE.
- RST mid-calibration: next cycle all outputs at reset values, no further CE; tap in delay element left as is.
- START while BUSY ignored; START in same cycle as RST ignored.
- START → BUSY/EN_VTC=0 one cycle later; LOAD0 pulse two cycles after START.
- Per tap: 1 (LOAD0/STEP) + SETTLE_CYCLES + ≥SAMPLE_CYCLES cycles. Full sweep with continuous SAMPLE_VALID: 3 + (MAX_TAP+1)(1+SETTLE+SAMPLE) − 1 + SETTLE + 1 cycles to DONE.
- CE, INC, LOAD are registered, single-cycle pulses; never asserted together with INC=1 and LOAD=1.

## Configuration
- IDLY_CAL_READBACK_EN defined: on the last SETTLE cycle (and last APPLY_SETTLE cycle) CNTVALUEOUT is compared to expected tap; mismatch → FAIL=1, jump to APPLY with FALLBACK_TAP, EYE_WIDTH=0.
- Not defined: CNTVALUEOUT ignored; no readback check logic.

## Test plan
- MAX_TAP=31, SETTLE=4, SAMPLE=4, MIN_EYE=4; taps 10..20 pass → CENTER_TAP=15, EYE_WIDTH=11, last LOAD with CNTVALUEIN=15, DONE one cycle, FAIL=0, EN_VTC back to 1.
- Windows 3..6 and 20..27 → CENTER_TAP=24, EYE_WIDTH=8; tie 2..5 and 10..13 → CENTER_TAP=4 (earliest).
- All taps fail (and separately 3-tap window) → FAIL=1, CNTVALUEIN=FALLBACK_TAP, DONE pulses.
- SAMPLE_VALID gapped 50% with one SAMPLE_OK=0 on an invalid cycle → tap still passes; one INC pulse per tap, 32 taps swept, no decrement.
- RST asserted mid-SAMPLE at tap 12 → next cycle all outputs reset values; new START restarts from LOAD0 with tap 0.
- IDLY_CAL_READBACK_EN: CNTVALUEOUT stuck at 0 → FAIL at end of tap 1 settle, EYE_WIDTH=0, FALLBACK_TAP loaded.
